// File: rtl/seq_det_pkg.sv
// seq_det_pkg: FSM state encoding and target pattern shared by the 101 generator and its detectors
package seq_det_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
  localparam logic [2:0] SEQ_PATTERN = 3'b101;
  localparam int SEQ_PATTERN_LEN = 3;
endpackage

// File: rtl/seq_exp_model.sv
// seq_exp_model: counts overlapping SEQ_PATTERN occurrences in a consumed bit stream (saturating)
module seq_exp_model
  import seq_det_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             serial_bit,
  output logic             exp_hit,
  output logic [CNT_W-1:0] exp_count
);
  logic [SEQ_PATTERN_LEN-2:0] hist;
  logic hit;
  assign hit = bit_valid && ({hist, serial_bit} == SEQ_PATTERN);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hist      <= '0;
      exp_hit   <= 1'b0;
      exp_count <= '0;
    end else begin
      hist      <= clear ? '0 : bit_valid ? {hist[SEQ_PATTERN_LEN-3:0], serial_bit} : hist;
      exp_hit   <= hit;
      exp_count <= (hit && !(&exp_count)) ? exp_count + 1'b1 : exp_count;
    end
endmodule

// File: rtl/seq_gen_101_tx.sv
// seq_gen_101_tx: paced parallel-to-serial transmitter feeding the 101 detectors.
// Define SEQ_GEN_EXPECT_EN to build in the reference hit counter (exp_hit/exp_count).
module seq_gen_101_tx
  import seq_det_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 16,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             bit_en,
  output logic             x,
  output logic             x_valid,
  output logic             last,
  output logic             busy,
  output logic             exp_hit,
  output logic [CNT_W-1:0] exp_count
);
  localparam int BW = $clog2(WIDTH);
  state_t state, state_d;
  logic [WIDTH-1:0] sh, sh_d;
  logic [BW-1:0] bit_cnt, bit_cnt_d;
  logic accept, consume;
  assign x_valid    = state == SHIFT;
  assign busy       = x_valid;
  assign last       = x_valid && bit_cnt == BW'(WIDTH-1);
  assign load_ready = !x_valid || (last && bit_en);
  assign accept     = load_valid && load_ready;
  assign consume    = x_valid && bit_en;
  // x is taken straight from the shift-register flop; the final shift empties it so IDLE shows 0
  assign x          = (LSB_FIRST != 0) ? sh[0] : sh[WIDTH-1];
  always_comb begin
    state_d   = accept ? SHIFT : (last && bit_en) ? IDLE : state;
    bit_cnt_d = (accept || (consume && last)) ? '0 : consume ? bit_cnt + 1'b1 : bit_cnt;
    sh_d      = accept ? load_data : !consume ? sh : (LSB_FIRST != 0) ? sh >> 1 : sh << 1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      sh      <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_d;
      sh      <= sh_d;
      bit_cnt <= bit_cnt_d;
    end
`ifdef SEQ_GEN_EXPECT_EN
  seq_exp_model #(.CNT_W(CNT_W)) u_exp (
    .clk       (clk),
    .rst       (rst),
    .clear     (!x_valid),
    .bit_valid (consume),
    .serial_bit(x),
    .exp_hit   (exp_hit),
    .exp_count (exp_count)
  );
`else
  assign exp_hit   = 1'b0;
  assign exp_count = '0;
`endif
endmodule

// File: tb/tb_seq_gen_101_tx.sv
// tb_seq_gen_101_tx: directed checks of the 101 stream transmitter (MSB-first default and LSB-first/2-bit-counter instances)
module tb_seq_gen_101_tx;
`ifdef SEQ_GEN_EXPECT_EN
  localparam bit EXP_EN = 1'b1;
`else
  localparam bit EXP_EN = 1'b0;
`endif
  logic clk, rst;
  logic lv, lr, be, x, xv, last, busy, eh;
  logic [7:0] ld;
  logic [15:0] ec;
  logic lv2, lr2, be2, x2, xv2, last2, busy2, eh2;
  logic [7:0] ld2;
  logic [1:0] ec2;
  int total, bad;

  seq_gen_101_tx dut (
    .clk(clk), .rst(rst), .load_valid(lv), .load_data(ld), .load_ready(lr), .bit_en(be),
    .x(x), .x_valid(xv), .last(last), .busy(busy), .exp_hit(eh), .exp_count(ec)
  );
  seq_gen_101_tx #(.WIDTH(8), .CNT_W(2), .LSB_FIRST(1)) dut2 (
    .clk(clk), .rst(rst), .load_valid(lv2), .load_data(ld2), .load_ready(lr2), .bit_en(be2),
    .x(x2), .x_valid(xv2), .last(last2), .busy(busy2), .exp_hit(eh2), .exp_count(ec2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; lv = 1'b0; be = 1'b1; lv2 = 1'b0; be2 = 1'b1;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    step();
    total++;
    if ({x, xv, last, busy, lr, eh} !== 6'b000010) begin
      bad++; $display("FAIL reset_outputs got %b want 000010", {x, xv, last, busy, lr, eh});
    end
    total++;
    if (ec !== 16'd0) begin bad++; $display("FAIL reset_count got %0d want 0", ec); end
    total++;
    if ({x2, xv2, last2, busy2, lr2, eh2, ec2} !== 8'b00001000) begin
      bad++; $display("FAIL reset_dut2 got %b want 00001000", {x2, xv2, last2, busy2, lr2, eh2, ec2});
    end
  endtask

  task automatic test_single();
    logic [7:0] w;
    w = 8'b0111_0100;
    do_reset();
    lv = 1'b1; ld = w; be = 1'b1;
    #1;
    total++;
    if (lr !== 1'b1) begin bad++; $display("FAIL single_ready_idle got %b want 1", lr); end
    step();
    lv = 1'b0; ld = 8'h00;
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({x, xv, last, busy} !== {w[7-i], 1'b1, i == 7, 1'b1}) begin
        bad++; $display("FAIL single_bit%0d got %b want %b", i, {x, xv, last, busy}, {w[7-i], 1'b1, i == 7, 1'b1});
      end
      total++;
      if (eh !== (EXP_EN && i == 6)) begin
        bad++; $display("FAIL single_hit%0d got %b want %b", i, eh, EXP_EN && i == 6);
      end
      step();
    end
    total++;
    if ({x, xv, busy} !== 3'b000) begin bad++; $display("FAIL single_idle got %b want 000", {x, xv, busy}); end
    total++;
    if (ec !== (EXP_EN ? 16'd1 : 16'd0)) begin bad++; $display("FAIL single_count got %0d want %0d", ec, EXP_EN ? 1 : 0); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] s;
    s = {8'hAA, 8'h81};
    do_reset();
    lv = 1'b1; ld = 8'hAA; be = 1'b1;
    step();
    ld = 8'h81;
    for (int i = 0; i < 16; i++) begin
      total++;
      if ({x, xv, busy, lr} !== {s[15-i], 1'b1, 1'b1, i == 7 || i == 15}) begin
        bad++; $display("FAIL b2b_bit%0d got %b want %b", i, {x, xv, busy, lr}, {s[15-i], 1'b1, 1'b1, i == 7 || i == 15});
      end
      step();
      if (i == 7) lv = 1'b0;
    end
    total++;
    if (xv !== 1'b0) begin bad++; $display("FAIL b2b_end_valid got %b want 0", xv); end
    total++;
    if (ec !== (EXP_EN ? 16'd4 : 16'd0)) begin bad++; $display("FAIL b2b_count got %0d want %0d", ec, EXP_EN ? 4 : 0); end
  endtask

  task automatic test_pacing();
    logic [7:0] w;
    w = 8'hA5;
    do_reset();
    be = 1'b0; lv = 1'b1; ld = w;
    #1;
    total++;
    if (lr !== 1'b1) begin bad++; $display("FAIL pace_ready_idle got %b want 1", lr); end
    step();
    lv = 1'b0;
    for (int c = 0; c < 24; c++) begin
      be = (c % 3 == 2);
      #1;
      total++;
      if ({x, xv, busy, lr} !== {w[7-c/3], 1'b1, 1'b1, c == 23}) begin
        bad++; $display("FAIL pace_cyc%0d got %b want %b", c, {x, xv, busy, lr}, {w[7-c/3], 1'b1, 1'b1, c == 23});
      end
      step();
    end
    total++;
    if (xv !== 1'b0) begin bad++; $display("FAIL pace_end_valid got %b want 0", xv); end
    total++;
    if (ec !== (EXP_EN ? 16'd2 : 16'd0)) begin bad++; $display("FAIL pace_count got %0d want %0d", ec, EXP_EN ? 2 : 0); end
  endtask

  task automatic test_lsb_first();
    logic [7:0] w;
    w = 8'b0000_0101;
    do_reset();
    lv2 = 1'b1; ld2 = w; be2 = 1'b1;
    step();
    lv2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({x2, xv2, last2} !== {w[i], 1'b1, i == 7}) begin
        bad++; $display("FAIL lsb_bit%0d got %b want %b", i, {x2, xv2, last2}, {w[i], 1'b1, i == 7});
      end
      step();
    end
    total++;
    if (xv2 !== 1'b0) begin bad++; $display("FAIL lsb_end_valid got %b want 0", xv2); end
    total++;
    if (ec2 !== (EXP_EN ? 2'd1 : 2'd0)) begin bad++; $display("FAIL lsb_count got %0d want %0d", ec2, EXP_EN ? 1 : 0); end
  endtask

  task automatic test_saturate();
    int n;
    do_reset();
    lv2 = 1'b1; ld2 = 8'hAA; be2 = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      n = (i >= 4) ? (i - 2) / 2 : 0;
      if (n > 3) n = 3;
      total++;
      if ({x2, xv2} !== {i[0], 1'b1}) begin
        bad++; $display("FAIL sat_bit%0d got %b want %b", i, {x2, xv2}, {i[0], 1'b1});
      end
      total++;
      if (ec2 !== 2'(EXP_EN ? n : 0)) begin
        bad++; $display("FAIL sat_count%0d got %0d want %0d", i, ec2, EXP_EN ? n : 0);
      end
      step();
      if (i == 7) lv2 = 1'b0;
    end
    total++;
    if ({xv2, ec2} !== {1'b0, (EXP_EN ? 2'd3 : 2'd0)}) begin
      bad++; $display("FAIL sat_final got %b want %b", {xv2, ec2}, {1'b0, (EXP_EN ? 2'd3 : 2'd0)});
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    w = 8'h05;
    do_reset();
    lv = 1'b1; ld = 8'hFF; be = 1'b1;
    step();
    lv = 1'b0;
    step();
    step();
    step();
    total++;
    if ({x, xv, busy} !== 3'b111) begin bad++; $display("FAIL mid_pre got %b want 111", {x, xv, busy}); end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({x, xv, busy, last, lr} !== 5'b00001) begin
      bad++; $display("FAIL mid_async got %b want 00001", {x, xv, busy, last, lr});
    end
    total++;
    if (ec !== 16'd0) begin bad++; $display("FAIL mid_count got %0d want 0", ec); end
    step();
    rst = 1'b1;
    lv = 1'b1; ld = w;
    step();
    lv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({x, xv} !== {w[7-i], 1'b1}) begin
        bad++; $display("FAIL mid_new_bit%0d got %b want %b", i, {x, xv}, {w[7-i], 1'b1});
      end
      step();
    end
    total++;
    if (ec !== (EXP_EN ? 16'd1 : 16'd0)) begin bad++; $display("FAIL mid_new_count got %0d want %0d", ec, EXP_EN ? 1 : 0); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; lv = 1'b0; ld = 8'h00; be = 1'b1;
    lv2 = 1'b0; ld2 = 8'h00; be2 = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_pacing();
    test_lsb_first();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
